ota_trim_sar_ctrl: RTL

- Digital calibration controller for the fully-differential OTA (vinp/vinn in, voutp/voutn out).
- Drives the OTA's input-short switch and a binary-weighted offset-trim DAC code.
- Reads back a clocked comparator that senses voutp vs voutn.
- Runs a successive-approximation search, MSB first, to null the output offset, then holds the final trim code.

---
 rtl/ota_trim_sar_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/ota_trim_sar_ctrl.sv
// Offset-trim calibration controller for the fully-differential OTA.
// The controller shorts the OTA inputs and then runs an MSB-first
// successive-approximation search on the trim DAC code, using the clocked
// comparator on voutp/voutn. When the search ends it holds the final code.
module ota_trim_sar_ctrl #(
    parameter int TRIM_W     = 6,
    parameter int SETTLE_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmp_in,
    output logic              cal_en,
    output logic [TRIM_W-1:0] trim_code,
    output logic              busy,
    output logic              done,
    output logic              sat
);

    localparam int IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_MSB  = IDX_W'(TRIM_W - 1);
    localparam logic [TRIM_W-1:0] MIDSCALE = {1'b1, {(TRIM_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [TRIM_W-1:0] resolved_code;
    logic              resolved_sat;

    // Code after resolving the current bit from the comparator and arming the next trial bit
    always_comb begin
        resolved_code = trim_code;
        if (cmp_in) begin
            resolved_code[idx] = 1'b0;
        end
        if (idx != '0) begin
            resolved_code[idx - 1'b1] = 1'b1;
        end
        resolved_sat = (resolved_code == '0) || (resolved_code == '1);
    end

    // Calibration sequencer: settle, sample, step to the next bit, then report
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            trim_code <= MIDSCALE;
            idx       <= IDX_MSB;
            cnt       <= '0;
            cal_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sat       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SETTLE;
                        trim_code <= MIDSCALE;
                        idx       <= IDX_MSB;
                        cnt       <= '0;
                        cal_en    <= 1'b1;
                        busy      <= 1'b1;
                        sat       <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        state <= SAMPLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    trim_code <= resolved_code;
                    if (idx != '0) begin
                        idx   <= idx - 1'b1;
                        cnt   <= '0;
                        state <= SETTLE;
                    end else begin
                        state  <= DONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        cal_en <= 1'b0;
                        sat    <= resolved_sat;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
